// File: rtl/can_rx_destuff_pkg.sv
// Shared types and constants for the CAN receive bit de-stuffer.
package can_pkg;

    // Receiver states, also driven out on the debug state port.
    typedef enum logic [1:0] {
        IDLE_WAIT = 2'd0,
        IDLE      = 2'd1,
        FRAME     = 2'd2,
        ERROR     = 2'd3
    } can_state_e;

    // Bus levels: dominant wins on the wire.
    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    // Default parameter values for the de-stuffer.
    localparam int STUFF_LEN_DEF = 5;
    localparam int IDLE_BITS_DEF = 11;

    // Counter widths: both counters saturate at all-ones.
    localparam int RUN_W  = 3;
    localparam int IDLE_W = 4;

endpackage

// File: rtl/can_run_counter.sv
// Saturating consecutive-bit counter with clear / load-one / increment.
// Priority is clear > load-one > increment; it never wraps past all-ones.
module can_run_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         set1_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, restart a run at one, or step and stick at max.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (set1_i) begin
            cnt_d = W'(1);
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/can_rx_destuff.sv
// CAN receive bit de-stuffer: detects bus idle, marks SOF, removes stuff
// bits inside the stuffed region and flags stuff-rule violations.
// Handshake: din_valid is a one-cycle strobe qualifying din; the block has
// no backpressure. dout_valid is a one-cycle strobe one clock after the
// accepted din_valid; dout holds its value between strobes.
module can_rx_destuff
    import can_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF,
    parameter int IDLE_BITS = IDLE_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    input  logic       din_valid,
    input  logic       stuff_en,
    input  logic       frame_end,
    output logic       dout,
    output logic       dout_valid,
    output logic       sof,
    output logic       stuff_err,
    output logic       bus_idle,
    output logic [1:0] dbg_state
);

    localparam logic [RUN_W-1:0]  STUFF_CNT = RUN_W'(STUFF_LEN);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);

    can_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              sof_q, sof_d;
    logic              stuff_err_q, stuff_err_d;
    logic              bus_idle_q, bus_idle_d;

    logic              run_clr, run_set1, run_inc;
    logic              idle_clr, idle_inc;
    logic [RUN_W-1:0]  run_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    can_run_counter #(.W(RUN_W)) u_run_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (run_clr),
        .set1_i (run_set1),
        .inc_i  (run_inc),
        .cnt_o  (run_cnt)
    );

    can_run_counter #(.W(IDLE_W)) u_idle_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (idle_clr),
        .set1_i (1'b0),
        .inc_i  (idle_inc),
        .cnt_o  (idle_cnt)
    );

    // Next state, counter controls and next registered outputs.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sof_d        = 1'b0;
        stuff_err_d  = 1'b0;
        run_clr      = 1'b0;
        run_set1     = 1'b0;
        run_inc      = 1'b0;
        idle_clr     = 1'b0;
        idle_inc     = 1'b0;

        if (!en) begin
            // Disabled: abort silently and restart idle detection.
            state_d  = IDLE_WAIT;
            run_clr  = 1'b1;
            idle_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE_WAIT: begin
                    run_clr = 1'b1;
                    if (din_valid) begin
                        if (din == RECESSIVE) begin
                            idle_inc = 1'b1;
                            if (idle_cnt >= IDLE_LAST) begin
                                state_d = IDLE;
                            end
                        end else begin
                            idle_clr = 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (din_valid && (din == DOMINANT)) begin
                        state_d      = FRAME;
                        dout_d       = din;
                        dout_valid_d = 1'b1;
                        sof_d        = 1'b1;
                        run_set1     = 1'b1;
                        last_d       = DOMINANT;
                    end else begin
                        run_clr = 1'b1;
                    end
                end
                FRAME: begin
                    idle_clr = 1'b1;
                    if (frame_end) begin
                        // End of frame takes precedence over a coincident bit.
                        state_d = IDLE_WAIT;
                        run_clr = 1'b1;
                    end else if (din_valid) begin
                        if (!stuff_en) begin
                            dout_d       = din;
                            dout_valid_d = 1'b1;
                            last_d       = din;
                            run_clr      = 1'b1;
                        end else if (run_cnt == STUFF_CNT) begin
                            if (din != last_q) begin
                                // Valid stuff bit: swallow it, it opens a new run.
                                run_set1 = 1'b1;
                                last_d   = din;
                            end else begin
                                stuff_err_d = 1'b1;
                                state_d     = ERROR;
                                run_clr     = 1'b1;
                            end
                        end else begin
                            dout_d       = din;
                            dout_valid_d = 1'b1;
                            last_d       = din;
                            // A zero count means stuffing just re-enabled.
                            if ((run_cnt != '0) && (din == last_q)) begin
                                run_inc = 1'b1;
                            end else begin
                                run_set1 = 1'b1;
                            end
                        end
                    end
                end
                ERROR: begin
                    state_d  = IDLE_WAIT;
                    run_clr  = 1'b1;
                    idle_clr = 1'b1;
                end
                default: begin
                    state_d  = IDLE_WAIT;
                    run_clr  = 1'b1;
                    idle_clr = 1'b1;
                end
            endcase
        end

        bus_idle_d = (state_d == IDLE);
    end

    // State and output registers; outputs come only from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE_WAIT;
            last_q       <= RECESSIVE;
            dout_q       <= RECESSIVE;
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            stuff_err_q  <= 1'b0;
            bus_idle_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sof_q        <= sof_d;
            stuff_err_q  <= stuff_err_d;
            bus_idle_q   <= bus_idle_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sof        = sof_q;
    assign stuff_err  = stuff_err_q;
    assign bus_idle   = bus_idle_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_can_rx_destuff.sv
// Self-checking bench for can_rx_destuff: frames are built from payload
// bits by a CAN bit-stuffing encoder, expected payload bits go into a
// queue and a negedge monitor compares every dout_valid strobe.
module tb_can_rx_destuff;
    import can_pkg::*;

    localparam int SL = 5;
    localparam int IB = 11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       din;
    logic       din_valid;
    logic       stuff_en;
    logic       frame_end;
    logic       dout;
    logic       dout_valid;
    logic       sof;
    logic       stuff_err;
    logic       bus_idle;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];   // {sof, dout}
    int exp_err = 0;
    int obs_err = 0;

    // Encoder state for the stuffed stream being sent.
    int   run_m;
    logic last_m;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    can_rx_destuff #(.STUFF_LEN(SL), .IDLE_BITS(IB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .stuff_en   (stuff_en),
        .frame_end  (frame_end),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sof        (sof),
        .stuff_err  (stuff_err),
        .bus_idle   (bus_idle),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dout_valid", 1, 0);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check("dout", int'(dout), int'(e[0]));
                    check("sof", int'(sof), int'(e[1]));
                end
            end
            if (stuff_err) begin
                obs_err++;
                check("stuff_err_without_valid", int'(dout_valid), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b, input logic se);
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
        stuff_en  = se;
        @(negedge clk);
        din_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
    endtask

    task automatic start_frame();
        exp_q.push_back(2'b10);
        send_bit(1'b0, 1'b1);
        run_m  = 1;
        last_m = 1'b0;
    endtask

    // Encoder: after SL equal bits a complement stuff bit precedes the data.
    task automatic stuffed_bit(input logic b);
        if (run_m == SL) begin
            send_bit(~last_m, 1'b1);
            last_m = ~last_m;
            run_m  = 1;
        end
        exp_q.push_back({1'b0, b});
        send_bit(b, 1'b1);
        if (run_m != 0 && b == last_m) run_m++;
        else run_m = 1;
        last_m = b;
    endtask

    task automatic plain_bit(input logic b);
        exp_q.push_back({1'b0, b});
        send_bit(b, 1'b0);
        run_m  = 0;
        last_m = b;
    endtask

    task automatic end_frame();
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    task automatic check_idle_after(input string tag);
        check({tag, "_idle_before"}, int'(bus_idle), 0);
        send_idle(IB - 1);
        check({tag, "_idle_after10"}, int'(bus_idle), 0);
        send_idle(1);
        @(negedge clk);
        check({tag, "_idle_after11"}, int'(bus_idle), 1);
    endtask

    task automatic random_frame(input int idx, input bit inject_err);
        int n;
        logic b;
        n = $urandom_range(4, 20);
        start_frame();
        for (int i = 0; i < n; i++) begin
            b = ($urandom_range(0, 9) < 7) ? last_m : ~last_m;
            stuffed_bit(b);
        end
        if (inject_err) begin
            while (run_m < SL) stuffed_bit(last_m);
            exp_err++;
            send_bit(last_m, 1'b1);
            repeat (2) @(negedge clk);
            check($sformatf("rand%0d_err_state", idx), int'(dbg_state), int'(IDLE_WAIT));
        end else begin
            n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) plain_bit(1'($urandom_range(0, 1)));
            end_frame();
            check($sformatf("rand%0d_end_state", idx), int'(dbg_state), int'(IDLE_WAIT));
        end
        check($sformatf("rand%0d_err_count", idx), obs_err, exp_err);
        check_idle_after($sformatf("rand%0d", idx));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        din       = 1'b1;
        din_valid = 1'b0;
        stuff_en  = 1'b0;
        frame_end = 1'b0;
        run_m     = 0;
        last_m    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_dout", int'(dout), 1);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_sof", int'(sof), 0);
        check("rst_stuff_err", int'(stuff_err), 0);
        check("rst_bus_idle", int'(bus_idle), 0);
        check("rst_state", int'(dbg_state), int'(IDLE_WAIT));
        rst_n = 1'b1;

        // No frame before idle is seen; 10 recessive + dominant is not idle.
        send_bit(1'b0, 1'b1);
        send_idle(IB - 1);
        check("pre_idle_10", int'(bus_idle), 0);
        send_bit(1'b0, 1'b0);
        check("pre_idle_dominant", int'(bus_idle), 0);
        check_idle_after("boot");

        // Stuff bit after five zeros is dropped.
        start_frame();
        for (int i = 0; i < 4; i++) stuffed_bit(1'b0);
        stuffed_bit(1'b1);
        end_frame();
        check("stuff_queue_empty", exp_q.size(), 0);
        check("stuff_no_err", obs_err, 0);
        check_idle_after("stuff");

        // Six equal bits violate stuffing.
        start_frame();
        for (int i = 0; i < 4; i++) stuffed_bit(1'b0);
        exp_err++;
        send_bit(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("err_count", obs_err, exp_err);
        check("err_state", int'(dbg_state), int'(IDLE_WAIT));
        check("err_queue_empty", exp_q.size(), 0);
        check_idle_after("err");

        // Unstuffed region forwards eight ones unchecked.
        start_frame();
        for (int i = 0; i < 8; i++) plain_bit(1'b1);
        end_frame();
        check("plain_queue_empty", exp_q.size(), 0);
        check("plain_err_count", obs_err, exp_err);
        check_idle_after("plain");

        // frame_end beats a coincident bit.
        start_frame();
        stuffed_bit(1'b1);
        stuffed_bit(1'b0);
        @(negedge clk);
        din       = 1'b1;
        din_valid = 1'b1;
        frame_end = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        frame_end = 1'b0;
        repeat (2) @(negedge clk);
        check("fe_state", int'(dbg_state), int'(IDLE_WAIT));
        check("fe_queue_empty", exp_q.size(), 0);
        check_idle_after("fe");

        // en dropped mid-frame aborts without an error.
        start_frame();
        for (int i = 0; i < 3; i++) stuffed_bit(1'b0);
        @(negedge clk);
        en        = 1'b0;
        din       = 1'b0;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        check("en_state", int'(dbg_state), int'(IDLE_WAIT));
        check("en_err_count", obs_err, exp_err);
        en = 1'b1;
        check_idle_after("en");

        // Asynchronous reset mid-frame.
        start_frame();
        stuffed_bit(1'b1);
        stuffed_bit(1'b1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dout", int'(dout), 1);
        check("arst_dout_valid", int'(dout_valid), 0);
        check("arst_sof", int'(sof), 0);
        check("arst_stuff_err", int'(stuff_err), 0);
        check("arst_bus_idle", int'(bus_idle), 0);
        check("arst_state", int'(dbg_state), int'(IDLE_WAIT));
        check("arst_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b0, 1'b1);
        check_idle_after("arst");

        // Randomized frames, some with an injected stuff violation.
        for (int f = 0; f < 30; f++) begin
            random_frame(f, ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_err_count", obs_err, exp_err);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
